// File: rtl/ship_pkg.sv
// Shared types and constants for the player-ship state controller.
// Headings are one-hot vectors in {up,down,right,left} order.
package ship_pkg;

    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ALIVE,
        EXPLODE,
        RESPAWN,
        GAME_OVER
    } ship_state_t;

    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0001;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/ship_state_ctrl_frame_counter.sv
// Frame counter for explosion and invulnerability timing: tick-qualified increment,
// priority clear, equality terminal compare. SHIP_BLINK_EN selects the blink phase output.
module frame_counter
    import ship_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tick_i,
    input  logic             inc_en_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             at_term_o,
    output logic             phase_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: combinational blocks assign every output a default first so no path leaves a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_i && inc_en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_term_o = (cnt_q == term_i);

    // Blink phase follows the count the ship will show next frame; constant when compiled out.
`ifdef SHIP_BLINK_EN
    assign phase_o = cnt_d[3];
`else
    assign phase_o = 1'b1;
`endif

endmodule

// File: rtl/ship_state_ctrl.sv
// Player-ship frame sequencer: steering latch, hit capture, explosion/respawn/game-over flow.
// Optional SHIP_BLINK_EN makes the ship blink during the post-respawn invulnerability window.
module ship_state_ctrl
    import ship_pkg::*;
#(
    parameter int unsigned LIVES_INIT    = 3,
    parameter int unsigned EXP_FRAMES    = 32,
    parameter int unsigned INVULN_FRAMES = 120
) (
    input  logic       VGA_Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [3:0] key_dir,
    input  logic       hit,
    output logic [3:0] direction,
    output logic       collision,
    output logic       ship_visible,
    output logic       hit_enable,
    output logic [2:0] lives,
    output logic       game_over
);

    localparam logic [2:0]       LIVES_LOAD = 3'(LIVES_INIT);
    localparam logic [CNT_W-1:0] EXP_TERM   = CNT_W'(EXP_FRAMES - 1);
    localparam logic [CNT_W-1:0] INV_TERM   = CNT_W'(INVULN_FRAMES - 1);

    ship_state_t state_q, state_d;
    logic [3:0]  dir_q, dir_d;
    logic [2:0]  lives_q, lives_d;
    logic        hit_pend_q, hit_pend_d;
    logic        collision_q, collision_d;
    logic        ship_visible_q, ship_visible_d;
    logic        hit_enable_q, hit_enable_d;
    logic        game_over_q, game_over_d;

    logic             hit_now;
    logic             steer;
    logic             cnt_clr;
    logic             cnt_run;
    logic             cnt_at_term;
    logic             blink_phase;
    logic [CNT_W-1:0] cnt_term;

    assign cnt_run  = (state_q == EXPLODE) || (state_q == RESPAWN);
    assign cnt_term = (state_q == EXPLODE) ? EXP_TERM : INV_TERM;

    frame_counter u_frame_counter (
        .clk_i     (VGA_Clk),
        .rst_ni    (Reset_n),
        .tick_i    (frame_tick),
        .inc_en_i  (cnt_run),
        .clr_i     (cnt_clr),
        .term_i    (cnt_term),
        .at_term_o (cnt_at_term),
        .phase_o   (blink_phase)
    );

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        lives_d    = lives_q;
        cnt_clr    = 1'b0;
        // A hit arriving on the consuming tick itself still counts on that tick.
        hit_now    = hit_pend_q | (hit & hit_enable_q);
        hit_pend_d = hit_now;
        steer      = frame_tick && is_onehot4(key_dir);

        case (state_q)
            IDLE, GAME_OVER: begin
                if (start) begin
                    lives_d = LIVES_LOAD;
                    dir_d   = DIR_UP;
                    cnt_clr = 1'b1;
                    state_d = ALIVE;
                end
            end
            ALIVE: begin
                if (frame_tick) begin
                    hit_pend_d = 1'b0;
                    if (hit_now) begin
                        lives_d = lives_q - 3'd1;
                        cnt_clr = 1'b1;
                        state_d = EXPLODE;
                    end else if (steer) begin
                        dir_d = key_dir;
                    end
                end
            end
            EXPLODE: begin
                if (frame_tick && cnt_at_term) begin
                    cnt_clr = 1'b1;
                    if (lives_q == 3'd0) begin
                        state_d = GAME_OVER;
                    end else begin
                        dir_d   = DIR_UP;
                        state_d = RESPAWN;
                    end
                end
            end
            RESPAWN: begin
                if (steer) begin
                    dir_d = key_dir;
                end
                if (frame_tick && cnt_at_term) begin
                    cnt_clr = 1'b1;
                    state_d = ALIVE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        collision_d    = (state_d == EXPLODE);
        hit_enable_d   = (state_d == ALIVE);
        game_over_d    = (state_d == GAME_OVER);
        ship_visible_d = 1'b0;
        case (state_d)
            ALIVE, EXPLODE: ship_visible_d = 1'b1;
            RESPAWN:        ship_visible_d = blink_phase;
            default:        ship_visible_d = 1'b0;
        endcase
    end

    always_ff @(posedge VGA_Clk) begin
        if (!Reset_n) begin
            state_q        <= IDLE;
            dir_q          <= DIR_UP;
            lives_q        <= 3'd0;
            hit_pend_q     <= 1'b0;
            collision_q    <= 1'b0;
            ship_visible_q <= 1'b0;
            hit_enable_q   <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            dir_q          <= dir_d;
            lives_q        <= lives_d;
            hit_pend_q     <= hit_pend_d;
            collision_q    <= collision_d;
            ship_visible_q <= ship_visible_d;
            hit_enable_q   <= hit_enable_d;
            game_over_q    <= game_over_d;
        end
    end

    assign direction    = dir_q;
    assign collision    = collision_q;
    assign ship_visible = ship_visible_q;
    assign hit_enable   = hit_enable_q;
    assign lives        = lives_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_ship_state_ctrl.sv
// Scoreboard bench for ship_state_ctrl: directed game scenarios then random stimulus,
// expectations from a countdown-based behavioural model, compared by a negedge monitor.
module tb_ship_state_ctrl;

    localparam int LIVES = 3;
    localparam int EXP   = 32;
    localparam int INV   = 120;

    logic       VGA_Clk;
    logic       Reset_n;
    logic       frame_tick;
    logic       start;
    logic [3:0] key_dir;
    logic       hit;
    logic [3:0] direction;
    logic       collision;
    logic       ship_visible;
    logic       hit_enable;
    logic [2:0] lives;
    logic       game_over;

    ship_state_ctrl #(
        .LIVES_INIT    (LIVES),
        .EXP_FRAMES    (EXP),
        .INVULN_FRAMES (INV)
    ) dut (
        .VGA_Clk      (VGA_Clk),
        .Reset_n      (Reset_n),
        .frame_tick   (frame_tick),
        .start        (start),
        .key_dir      (key_dir),
        .hit          (hit),
        .direction    (direction),
        .collision    (collision),
        .ship_visible (ship_visible),
        .hit_enable   (hit_enable),
        .lives        (lives),
        .game_over    (game_over)
    );

    initial VGA_Clk = 1'b0;
    always #5 VGA_Clk = ~VGA_Clk;

    int cyc = 0;
    always @(posedge VGA_Clk) cyc <= cyc + 1;

    typedef struct {
        int         tag;
        logic [3:0] dir;
        logic       col;
        logic       vis;
        logic       hen;
        logic [2:0] lives;
        logic       over;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    typedef enum {M_IDLE, M_PLAY, M_BOOM, M_SHIELD, M_OVER} mode_t;
    mode_t      m_mode  = M_IDLE;
    int         m_lives = 0;
    logic [3:0] m_dir   = 4'b1000;
    int         m_left  = 0;
    bit         m_pend  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Game rules applied once per clock edge with the inputs present at that edge.
    task automatic model_step(input logic rst, input logic tick, input logic st,
                              input logic [3:0] key, input logic h);
        bit armed;
        bit pend_now;
        if (!rst) begin
            m_mode = M_IDLE; m_lives = 0; m_dir = 4'b1000; m_left = 0; m_pend = 0;
            return;
        end
        armed    = (m_mode == M_PLAY);
        pend_now = m_pend || (h && armed);
        m_pend   = pend_now;
        case (m_mode)
            M_IDLE, M_OVER: begin
                if (st) begin
                    m_lives = LIVES; m_dir = 4'b1000; m_mode = M_PLAY;
                end
            end
            M_PLAY: begin
                if (tick) begin
                    m_pend = 0;
                    if (pend_now) begin
                        m_lives = m_lives - 1; m_left = EXP; m_mode = M_BOOM;
                    end else if ($countones(key) == 1) begin
                        m_dir = key;
                    end
                end
            end
            M_BOOM: begin
                if (tick) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        if (m_lives == 0) m_mode = M_OVER;
                        else begin
                            m_dir = 4'b1000; m_left = INV; m_mode = M_SHIELD;
                        end
                    end
                end
            end
            default: begin
                if (tick) begin
                    if ($countones(key) == 1) m_dir = key;
                    m_left = m_left - 1;
                    if (m_left == 0) m_mode = M_PLAY;
                end
            end
        endcase
    endtask

    task automatic push_expect();
        exp_t e;
        e.tag   = cyc + 1;
        e.dir   = m_dir;
        e.col   = (m_mode == M_BOOM);
        e.hen   = (m_mode == M_PLAY);
        e.lives = 3'(m_lives);
        e.over  = (m_mode == M_OVER);
`ifdef SHIP_BLINK_EN
        if (m_mode == M_SHIELD) begin
            int elapsed;
            elapsed = INV - m_left;
            e.vis   = elapsed[3];
        end else begin
            e.vis = (m_mode == M_PLAY) || (m_mode == M_BOOM);
        end
`else
        e.vis = (m_mode == M_PLAY) || (m_mode == M_BOOM) || (m_mode == M_SHIELD);
`endif
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic rst, input logic tick, input logic st,
                         input logic [3:0] key, input logic h);
        @(posedge VGA_Clk);
        #1;
        Reset_n = rst; frame_tick = tick; start = st; key_dir = key; hit = h;
        model_step(rst, tick, st, key, h);
        push_expect();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b1, 1'b0, 4'($urandom_range(0, 15)), 1'b0);
            drive(1'b1, 1'b0, 1'b0, 4'($urandom_range(0, 15)), 1'b0);
        end
    endtask

    always @(negedge VGA_Clk) begin
        if (exp_q.size() != 0 && exp_q[0].tag <= cyc) begin
            mon_e = exp_q.pop_front();
            check("sample_slot", mon_e.tag, cyc);
            check("direction", direction, mon_e.dir);
            check("collision", collision, mon_e.col);
            check("ship_visible", ship_visible, mon_e.vis);
            check("hit_enable", hit_enable, mon_e.hen);
            check("lives", lives, mon_e.lives);
            check("game_over", game_over, mon_e.over);
        end
    end

    initial begin
        Reset_n = 1'b0; frame_tick = 1'b0; start = 1'b0; key_dir = 4'd0; hit = 1'b0;

        drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 4'd0, 1'b0);        // start from IDLE
        idle(2);
        drive(1'b1, 1'b1, 1'b0, 4'b0010, 1'b0);     // one-hot steer
        drive(1'b1, 1'b1, 1'b0, 4'b0110, 1'b0);     // multi-hot holds
        drive(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);     // zero holds
        drive(1'b1, 1'b0, 1'b1, 4'd0, 1'b0);        // start ignored while alive
        drive(1'b1, 1'b1, 1'b0, 4'b0001, 1'b1);     // hit with tick
        ticks(EXP);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);        // hit ignored in respawn
        ticks(INV);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);        // off-tick hit stays pending
        idle(3);
        drive(1'b1, 1'b1, 1'b0, 4'b0001, 1'b0);
        ticks(EXP);
        ticks(INV);
        drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b1);        // last life
        ticks(EXP);
        idle(2);
        drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b1);        // hit ignored in game over
        drive(1'b1, 1'b0, 1'b1, 4'd0, 1'b0);        // restart
        drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
        ticks(5);
        drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);        // reset mid-explosion
        idle(2);

        for (int i = 0; i < 20000; i++) begin
            drive(1'($urandom_range(0, 999) != 0),
                  1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 63) == 0),
                  4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 15) == 0));
        end

        repeat (3) @(posedge VGA_Clk);
        #1;
        check("queue_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
